// File: rtl/alu_secuenciador.sv
// alu_secuenciador: sequential front/back stage around the combinational 8-bit ALU.
// Accepts one command over a valid/ready handshake and registers it onto the ALU inputs.
// One cycle later it captures the ALU result, derives carry/zero/error flags locally,
// and holds the result on a valid/ready output until it is consumed.
// Divide/modulo by zero is screened here, so the ALU result is ignored for those cases.
module alu_secuenciador #(
    parameter int ANCHO = 8
) (
    input  logic                 reloj,
    input  logic                 reinicio_n,
    input  logic                 cmd_valido,
    output logic                 cmd_listo,
    input  logic [2:0]           cmd_op,
    input  logic [ANCHO-1:0]     cmd_a,
    input  logic [ANCHO-1:0]     cmd_b,
    output logic [2:0]           alu_op,
    output logic [ANCHO-1:0]     alu_dato0,
    output logic [ANCHO-1:0]     alu_dato1,
    input  logic [2*ANCHO-1:0]   alu_resultado,
    output logic                 res_valido,
    input  logic                 res_listo,
    output logic [2*ANCHO-1:0]   res_dato,
    output logic                 res_acarreo,
    output logic                 res_cero,
    output logic                 res_error,
    output logic [15:0]          cuenta_ops
);

    localparam logic [2:0] OP_SUM = 3'b000;
    localparam logic [2:0] OP_RES = 3'b001;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_MOD = 3'b100;

    typedef enum logic [1:0] {
        LIBRE   = 2'd0,
        CARGA   = 2'd1,
        ENTREGA = 2'd2
    } estado_t;

    estado_t estado_r;

    logic                 div_cero_s;
    logic [2*ANCHO-1:0]   cap_dato_s;
    logic                 cap_acarreo_s;
    logic                 cap_cero_s;
    logic                 cap_error_s;

    // Zero detect on a full-width result, done locally rather than trusting the ALU.
    function automatic logic es_cero(input logic [2*ANCHO-1:0] valor);
        return (valor == {(2*ANCHO){1'b0}});
    endfunction

    // Values that will be captured at the closing edge of CARGA.
    always_comb begin
        div_cero_s    = 1'b0;
        cap_dato_s    = alu_resultado;
        cap_acarreo_s = 1'b0;
        cap_cero_s    = 1'b0;
        cap_error_s   = 1'b0;
        case (alu_op)
            OP_DIV, OP_MOD: div_cero_s = (alu_dato1 == {ANCHO{1'b0}});
            default:        div_cero_s = 1'b0;
        endcase
        if (div_cero_s) begin
            // The ALU output is undefined here; substitute the error pattern.
            cap_dato_s    = {(2*ANCHO){1'b1}};
            cap_error_s   = 1'b1;
            cap_cero_s    = 1'b0;
            cap_acarreo_s = 1'b0;
        end else begin
            cap_dato_s  = alu_resultado;
            cap_error_s = 1'b0;
            cap_cero_s  = es_cero(alu_resultado);
            case (alu_op)
                // Bit ANCHO is the carry for SUM and the borrow for RES.
                OP_SUM, OP_RES: cap_acarreo_s = alu_resultado[ANCHO];
                default:        cap_acarreo_s = 1'b0;
            endcase
        end
    end

    // Control FSM with all outputs registered; reset is synchronous and active-low.
    always_ff @(posedge reloj) begin
        if (!reinicio_n) begin
            estado_r    <= LIBRE;
            cmd_listo   <= 1'b1;
            alu_op      <= 3'b000;
            alu_dato0   <= {ANCHO{1'b0}};
            alu_dato1   <= {ANCHO{1'b0}};
            res_valido  <= 1'b0;
            res_dato    <= {(2*ANCHO){1'b0}};
            res_acarreo <= 1'b0;
            res_cero    <= 1'b0;
            res_error   <= 1'b0;
            cuenta_ops  <= 16'd0;
        end else begin
            case (estado_r)
                LIBRE: begin
                    if (cmd_valido) begin
                        alu_op    <= cmd_op;
                        alu_dato0 <= cmd_a;
                        alu_dato1 <= cmd_b;
                        cmd_listo <= 1'b0;
                        estado_r  <= CARGA;
                    end else begin
                        estado_r  <= LIBRE;
                    end
                end
                CARGA: begin
                    res_dato    <= cap_dato_s;
                    res_acarreo <= cap_acarreo_s;
                    res_cero    <= cap_cero_s;
                    res_error   <= cap_error_s;
                    res_valido  <= 1'b1;
                    estado_r    <= ENTREGA;
                end
                ENTREGA: begin
                    if (res_listo) begin
                        res_valido <= 1'b0;
                        cuenta_ops <= cuenta_ops + 16'd1;
                        cmd_listo  <= 1'b1;
                        estado_r   <= LIBRE;
                    end else begin
                        estado_r   <= ENTREGA;
                    end
                end
                default: begin
                    // Unreachable encoding: recover to idle without producing a result.
                    res_valido <= 1'b0;
                    cmd_listo  <= 1'b1;
                    estado_r   <= LIBRE;
                end
            endcase
        end
    end

endmodule
